// File: rtl/alu_arbiter_2req.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// One operation in flight: IDLE (grant) -> EXEC (drive ALU, capture) -> RESP (return).
module alu_arbiter_2req #(
   parameter int WIDTH = 64,
   parameter int OPW   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OPW-1:0]   req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [OPW-1:0]   req1_op,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_result,
   output logic             rsp0_carry,
   output logic             rsp0_zero,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_result,
   output logic             rsp1_carry,
   output logic             rsp1_zero,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_s;
   logic               prio_r;
   logic               owner_r;
   logic               init_r;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic [OPW-1:0]     op_r;
   logic [WIDTH-1:0]   res0_r;
   logic               carry0_r;
   logic               zero0_r;
   logic [WIDTH-1:0]   res1_r;
   logic               carry1_r;
   logic               zero1_r;
   logic               win_s;
   logic               grant_ok_s;
   logic               accept_s;
   logic               rsp_done_s;

   // The ALU does not produce a zero flag, so it is derived here at capture.
   function automatic logic is_zero(input logic [WIDTH-1:0] v);
      return (v == {WIDTH{1'b0}});
   endfunction

   // Winner selection: lone valid requester wins, a tie goes to prio.
   always_comb begin
      win_s = 1'b0;
      if (req0_valid && req1_valid) begin
         win_s = prio_r;
      end else if (req1_valid) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
   end

   // Grant is withheld during reset and for the first cycle after it.
   always_comb begin
      grant_ok_s = 1'b0;
      if ((state_r == S_IDLE) && !rst && !init_r) begin
         grant_ok_s = 1'b1;
      end else begin
         grant_ok_s = 1'b0;
      end
   end

   // Request and response handshake detection.
   always_comb begin
      accept_s   = grant_ok_s && (req0_valid || req1_valid);
      rsp_done_s = 1'b0;
      if (state_r == S_RESP) begin
         rsp_done_s = owner_r ? rsp1_ready : rsp0_ready;
      end else begin
         rsp_done_s = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (accept_s) begin
               state_s = S_EXEC;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_EXEC: begin
            state_s = S_RESP;
         end
         S_RESP: begin
            if (rsp_done_s) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_RESP;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // Operand latch, round-robin pointer and per-channel result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         init_r   <= 1'b1;
         prio_r   <= 1'b0;
         owner_r  <= 1'b0;
         a_r      <= {WIDTH{1'b0}};
         b_r      <= {WIDTH{1'b0}};
         op_r     <= {OPW{1'b0}};
         res0_r   <= {WIDTH{1'b0}};
         carry0_r <= 1'b0;
         zero0_r  <= 1'b0;
         res1_r   <= {WIDTH{1'b0}};
         carry1_r <= 1'b0;
         zero1_r  <= 1'b0;
      end else begin
         init_r <= 1'b0;
         if (accept_s) begin
            owner_r <= win_s;
            prio_r  <= ~win_s;
            a_r     <= win_s ? req1_a  : req0_a;
            b_r     <= win_s ? req1_b  : req0_b;
            op_r    <= win_s ? req1_op : req0_op;
         end else if (state_r == S_EXEC) begin
            if (owner_r) begin
               res1_r   <= alu_result;
               carry1_r <= alu_carry;
               zero1_r  <= is_zero(alu_result);
            end else begin
               res0_r   <= alu_result;
               carry0_r <= alu_carry;
               zero0_r  <= is_zero(alu_result);
            end
         end else begin
            owner_r <= owner_r;
         end
      end
   end

   // Output decode; everything is forced low while reset is asserted.
   always_comb begin
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      rsp0_valid  = 1'b0;
      rsp1_valid  = 1'b0;
      rsp0_result = {WIDTH{1'b0}};
      rsp0_carry  = 1'b0;
      rsp0_zero   = 1'b0;
      rsp1_result = {WIDTH{1'b0}};
      rsp1_carry  = 1'b0;
      rsp1_zero   = 1'b0;
      alu_a       = {WIDTH{1'b0}};
      alu_b       = {WIDTH{1'b0}};
      alu_op      = {OPW{1'b0}};
      if (rst) begin
         req0_ready = 1'b0;
         req1_ready = 1'b0;
      end else begin
         req0_ready  = grant_ok_s && req0_valid && !win_s;
         req1_ready  = grant_ok_s && req1_valid && win_s;
         rsp0_valid  = (state_r == S_RESP) && !owner_r;
         rsp1_valid  = (state_r == S_RESP) && owner_r;
         rsp0_result = res0_r;
         rsp0_carry  = carry0_r;
         rsp0_zero   = zero0_r;
         rsp1_result = res1_r;
         rsp1_carry  = carry1_r;
         rsp1_zero   = zero1_r;
         alu_a       = a_r;
         alu_b       = b_r;
         alu_op      = op_r;
      end
   end

endmodule
